// File: rtl/brq_pkg.sv
// Shared types for the RVFI trace buffer: the packed trace record and the capture FSM states.
// Defining BRQ_TRACE_MEM_EN appends the memory-access fields at the LSB end of the record.
package brq_pkg;

  typedef enum logic [1:0] {
    TRACE_IDLE    = 2'd0,
    TRACE_CAPTURE = 2'd1,
    TRACE_FROZEN  = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic        gap;
    logic [15:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
    logic        halt;
    logic [1:0]  mode;
`ifdef BRQ_TRACE_MEM_EN
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
`endif
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/brq_trace_fifo.sv
// Generic synchronous FIFO with registered storage and no write-to-read bypass.
// Latency: a push becomes visible one cycle later. Backpressure: push_rdy drops when full unless a pop frees the slot.
module brq_trace_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_vld,
  output logic                   push_rdy,
  input  logic [Width-1:0]       push_dat,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [Width-1:0]       pop_dat,
  output logic [$clog2(Depth):0] fill
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = 1;

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             push_fire;
  logic             pop_fire;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_vld   = !empty;
  assign pop_fire  = pop_vld && pop_rdy;
  assign push_rdy  = !full || pop_fire;
  assign push_fire = push_vld && push_rdy;
  assign fill      = wr_ptr - rd_ptr;
  // Storage is not reset, so the head is masked to zero whenever nothing is valid.
  assign pop_dat   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PtrOne;
      if (pop_fire)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/brq_rvfi_trace_buffer.sv
// Captures one record per RVFI retirement into a circular buffer drained over valid/ready (BRQ_TRACE_MEM_EN adds mem fields).
// Latency: record visible the cycle after retirement. Backpressure: never stalls the core; overflow drops and counts records.
module brq_rvfi_trace_buffer
  import brq_pkg::*;
#(
  parameter int Depth        = 16,
  parameter int DropCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    capture_en_i,
  input  logic                    rvfi_valid,
  input  logic [63:0]             rvfi_order,
  input  logic [31:0]             rvfi_insn,
  input  logic                    rvfi_trap,
  input  logic                    rvfi_halt,
  input  logic                    rvfi_intr,
  input  logic [1:0]              rvfi_mode,
  input  logic [4:0]              rvfi_rd_addr,
  input  logic [31:0]             rvfi_rd_wdata,
  input  logic [31:0]             rvfi_pc_rdata,
`ifdef BRQ_TRACE_MEM_EN
  input  logic [31:0]             rvfi_mem_addr,
  input  logic [3:0]              rvfi_mem_rmask,
  input  logic [3:0]              rvfi_mem_wmask,
  input  logic [31:0]             rvfi_mem_wdata,
`endif
  output logic                    trace_valid_o,
  input  logic                    trace_ready_i,
  output trace_rec_t              trace_rdata_o,
  output logic [$clog2(Depth):0]  fill_o,
  output logic [DropCntWidth-1:0] drop_cnt_o,
  output logic [1:0]              state_o
);

  localparam logic [DropCntWidth-1:0] DropOne = 1;

  trace_state_e            state_q;
  logic                    gap_q;
  logic [DropCntWidth-1:0] drop_cnt_q;
  trace_rec_t              rec_d;
  logic [TRACE_REC_W-1:0]  fifo_rdata;
  logic                    push_req;
  logic                    push_rdy;
  logic                    push_acc;
  logic                    drop;
  logic                    unused_order_hi;

  assign unused_order_hi = ^rvfi_order[63:16];

  assign push_req = rvfi_valid && (state_q == TRACE_CAPTURE);
  assign push_acc = push_req && push_rdy;
  assign drop     = push_req && !push_rdy;

  always_comb begin
    rec_d          = '0;
    rec_d.gap      = gap_q;
    rec_d.order    = rvfi_order[15:0];
    rec_d.pc       = rvfi_pc_rdata;
    rec_d.insn     = rvfi_insn;
    rec_d.rd_addr  = rvfi_rd_addr;
    rec_d.rd_wdata = rvfi_rd_wdata;
    rec_d.trap     = rvfi_trap;
    rec_d.intr     = rvfi_intr;
    rec_d.halt     = rvfi_halt;
    rec_d.mode     = rvfi_mode;
`ifdef BRQ_TRACE_MEM_EN
    rec_d.mem_addr  = rvfi_mem_addr;
    rec_d.mem_rmask = rvfi_mem_rmask;
    rec_d.mem_wmask = rvfi_mem_wmask;
    rec_d.mem_wdata = rvfi_mem_wdata;
`endif
  end

  brq_trace_fifo #(
    .Width (TRACE_REC_W),
    .Depth (Depth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (push_req),
    .push_rdy (push_rdy),
    .push_dat (rec_d),
    .pop_vld  (trace_valid_o),
    .pop_rdy  (trace_ready_i),
    .pop_dat  (fifo_rdata),
    .fill     (fill_o)
  );

  assign trace_rdata_o = trace_rec_t'(fifo_rdata);

  // A halting retirement freezes capture even if its record was dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TRACE_IDLE;
    end else begin
      case (state_q)
        TRACE_IDLE:    if (capture_en_i) state_q <= TRACE_CAPTURE;
        TRACE_CAPTURE: begin
          if (push_req && rvfi_halt) state_q <= TRACE_FROZEN;
          else if (!capture_en_i)    state_q <= TRACE_IDLE;
        end
        TRACE_FROZEN:  if (!capture_en_i) state_q <= TRACE_IDLE;
        default:       state_q <= TRACE_IDLE;
      endcase
    end
  end

  // The gap flag marks the first record accepted after one or more drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (drop)          gap_q <= 1'b1;
      else if (push_acc) gap_q <= 1'b0;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DropOne;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_brq_rvfi_trace_buffer.sv
// Bench for brq_rvfi_trace_buffer: directed vector table, hand-written overflow/reset sequences,
// and randomized traffic against a queue-based model (BRQ_TRACE_MEM_EN adds a store-record check).
module tb_brq_rvfi_trace_buffer;
  import brq_pkg::*;

  localparam int DEPTH = 16;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap = 1'b0, vld = 1'b0, rdy = 1'b0;
  logic        trap = 1'b0, halt = 1'b0, intr = 1'b0;
  logic [63:0] order = '0;
  logic [31:0] insn = '0, rd_wdata = '0, pc = '0;
  logic [4:0]  rd_addr = '0;
  logic [1:0]  mode = '0;
`ifdef BRQ_TRACE_MEM_EN
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_rmask = '0, mem_wmask = '0;
`endif

  trace_rec_t  rd;
  logic        tv;
  logic [FW-1:0] fill;
  logic [15:0] drop;
  logic [1:0]  st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  brq_rvfi_trace_buffer #(.Depth(DEPTH), .DropCntWidth(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .capture_en_i  (cap),
    .rvfi_valid    (vld),
    .rvfi_order    (order),
    .rvfi_insn     (insn),
    .rvfi_trap     (trap),
    .rvfi_halt     (halt),
    .rvfi_intr     (intr),
    .rvfi_mode     (mode),
    .rvfi_rd_addr  (rd_addr),
    .rvfi_rd_wdata (rd_wdata),
    .rvfi_pc_rdata (pc),
`ifdef BRQ_TRACE_MEM_EN
    .rvfi_mem_addr  (mem_addr),
    .rvfi_mem_rmask (mem_rmask),
    .rvfi_mem_wmask (mem_wmask),
    .rvfi_mem_wdata (mem_wdata),
`endif
    .trace_valid_o (tv),
    .trace_ready_i (rdy),
    .trace_rdata_o (rd),
    .fill_o        (fill),
    .drop_cnt_o    (drop),
    .state_o       (st)
  );

  typedef struct {
    bit          cap, vld, rdy, halt;
    logic [31:0] pc;
    int          fill;
    bit          tv;
    logic [31:0] hpc;
    bit          gap;
    int          st;
    int          drop;
  } vec_t;

  vec_t tbl[16];
  logic [TRACE_REC_W-1:0] mq[$];
  bit mgap;
  int mdrop, mst;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chkr(input string nm, input logic [TRACE_REC_W-1:0] act,
                      input logic [TRACE_REC_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit v, input bit r, input bit h, input logic [31:0] p);
    cap = c; vld = v; rdy = r; halt = h; pc = p;
    order = order + 64'd1;
    insn = p ^ 32'h0000_0013;
    rd_addr = p[6:2];
    rd_wdata = ~p;
    trap = 1'b0; intr = 1'b0; mode = 2'd3;
  endtask

  // Expected record built field by field from the documented MSB-first layout.
  function automatic logic [TRACE_REC_W-1:0] mk(input bit g);
    return {g, order[15:0], pc, insn, rd_addr, rd_wdata, trap, intr, halt, mode
`ifdef BRQ_TRACE_MEM_EN
            , mem_addr, mem_rmask, mem_wmask, mem_wdata
`endif
           };
  endfunction

  task automatic drain_check(input logic [31:0] base, input logic [31:0] last, input bit last_gap);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", int'(tv), 1);
      chk("drain_pc", int'(rd.pc), (i < DEPTH-1) ? int'(base + 32'(4*i)) : int'(last));
      chk("drain_gap", int'(rd.gap), (i == DEPTH-1) ? int'(last_gap) : 0);
      drive(1, 0, 1, 0, 0);
      tick();
    end
    chk("drain_empty", int'(fill), 0);
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,32'h000, 0,0,32'h000,0,1,0};
    tbl[1]  = '{1,1,0,0,32'h100, 1,1,32'h100,0,1,0};
    tbl[2]  = '{1,1,0,0,32'h104, 2,1,32'h100,0,1,0};
    tbl[3]  = '{1,1,0,0,32'h108, 3,1,32'h100,0,1,0};
    tbl[4]  = '{1,0,1,0,32'h000, 2,1,32'h104,0,1,0};
    tbl[5]  = '{1,0,1,0,32'h000, 1,1,32'h108,0,1,0};
    tbl[6]  = '{1,0,1,0,32'h000, 0,0,32'h000,0,1,0};
    tbl[7]  = '{1,1,1,0,32'h10C, 1,1,32'h10C,0,1,0};
    tbl[8]  = '{1,0,1,0,32'h000, 0,0,32'h000,0,1,0};
    tbl[9]  = '{1,1,0,1,32'h200, 1,1,32'h200,0,2,0};
    tbl[10] = '{1,1,0,0,32'h204, 1,1,32'h200,0,2,0};
    tbl[11] = '{0,0,0,0,32'h000, 1,1,32'h200,0,0,0};
    tbl[12] = '{1,0,0,0,32'h000, 1,1,32'h200,0,1,0};
    tbl[13] = '{1,1,0,0,32'h208, 2,1,32'h200,0,1,0};
    tbl[14] = '{1,0,1,0,32'h000, 1,1,32'h208,0,1,0};
    tbl[15] = '{1,0,1,0,32'h000, 0,0,32'h000,0,1,0};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_fill", int'(fill), 0);
    chk("rst_valid", int'(tv), 0);
    chk("rst_drop", int'(drop), 0);
    chk("rst_state", int'(st), 0);
    chkr("rst_rdata", rd, '0);
    rst = 1'b0;

    // Directed vector table
    foreach (tbl[k]) begin
      drive(tbl[k].cap, tbl[k].vld, tbl[k].rdy, tbl[k].halt, tbl[k].pc);
      tick();
      chk($sformatf("vec%0d_fill", k), int'(fill), tbl[k].fill);
      chk($sformatf("vec%0d_valid", k), int'(tv), int'(tbl[k].tv));
      chk($sformatf("vec%0d_state", k), int'(st), tbl[k].st);
      chk($sformatf("vec%0d_drop", k), int'(drop), tbl[k].drop);
      if (tbl[k].tv) begin
        chk($sformatf("vec%0d_pc", k), int'(rd.pc), int'(tbl[k].hpc));
        chk($sformatf("vec%0d_gap", k), int'(rd.gap), int'(tbl[k].gap));
      end
    end

    // Overflow: 20 retirements into 16 entries, then gap on next accepted record
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0, 32'h1000 + 32'(4*i));
      tick();
    end
    chk("ovf_fill", int'(fill), 16);
    chk("ovf_drop", int'(drop), 4);
    drive(1, 0, 1, 0, 0);
    tick();
    chk("ovf_pop_fill", int'(fill), 15);
    chk("ovf_pop_head", int'(rd.pc), 32'h1004);
    drive(1, 1, 0, 0, 32'h2000);
    tick();
    chk("ovf_refill", int'(fill), 16);
    chk("ovf_drop_hold", int'(drop), 4);
    drain_check(32'h1004, 32'h2000, 1'b1);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 0, 0, 32'h3000 + 32'(4*i));
      tick();
    end
    chk("full_fill", int'(fill), 16);
    drive(1, 1, 1, 0, 32'h4000);
    tick();
    chk("pp_fill", int'(fill), 16);
    chk("pp_drop", int'(drop), 4);
    drain_check(32'h3004, 32'h4000, 1'b0);

    // Reset mid-operation with five records held
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 32'h5000 + 32'(4*i));
      tick();
    end
    chk("pre_rst_fill", int'(fill), 5);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0);
    tick();
    chk("mid_rst_fill", int'(fill), 0);
    chk("mid_rst_valid", int'(tv), 0);
    chk("mid_rst_drop", int'(drop), 0);
    chk("mid_rst_state", int'(st), 0);
    rst = 1'b0;

`ifdef BRQ_TRACE_MEM_EN
    drive(1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 32'h600);
    mem_addr = 32'h2000; mem_wmask = 4'hF; mem_rmask = 4'h0; mem_wdata = 32'hDEADBEEF;
    tick();
    chk("mem_addr", int'(rd.mem_addr), 32'h2000);
    chk("mem_wmask", int'(rd.mem_wmask), 4'hF);
    chk("mem_wdata", int'(rd.mem_wdata), 32'hDEADBEEF);
    chk("mem_rmask", int'(rd.mem_rmask), 0);
`endif

    // Randomized traffic against the queue model
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    mq.delete();
    mgap = 1'b0; mdrop = 0; mst = 0;
    for (int n = 0; n < 3000; n++) begin
      bit pop_m, push_m;
      int nst;
      drive(($urandom % 20) != 0, ($urandom % 10) < 7, $urandom % 2, ($urandom % 40) == 0, $urandom);
      trap = 1'($urandom); intr = 1'($urandom); mode = 2'($urandom);
      rd_addr = 5'($urandom); rd_wdata = $urandom; order = {$urandom, $urandom};
`ifdef BRQ_TRACE_MEM_EN
      mem_addr = $urandom; mem_wdata = $urandom;
      mem_rmask = 4'($urandom); mem_wmask = 4'($urandom);
`endif
      pop_m  = (mq.size() > 0) && rdy;
      push_m = vld && (mst == 1);
      nst = mst;
      if (mst == 0 && cap) nst = 1;
      else if (mst == 1 && push_m && halt) nst = 2;
      else if (mst != 0 && !cap) nst = 0;
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(mk(mgap));
          mgap = 1'b0;
        end else begin
          if (mdrop < 65535) mdrop++;
          mgap = 1'b1;
        end
      end
      mst = nst;
      tick();
      chk("rnd_fill", int'(fill), mq.size());
      chk("rnd_valid", int'(tv), int'(mq.size() > 0));
      chk("rnd_state", int'(st), mst);
      chk("rnd_drop", int'(drop), mdrop);
      if (mq.size() > 0) chkr("rnd_head", rd, mq[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
